// File: rtl/interp_tap_accumulator.sv
// Serial tap-product accumulator for the fractional-sample interpolator.
// Sums NTAPS signed products per output sample, then rounds, normalises and
// clips the sum to [0, 2^BITDEPTH-1]. The result is held in a single-entry
// valid/ready output register.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | cnt == 0, accumulator empty (a result may be held at the output)
//   ACC   | 0 < cnt < NTAPS, partial sum in progress
module interp_tap_accumulator #(
    parameter int NTAPS    = 8,
    parameter int IN_W     = 32,
    parameter int SHIFT    = 6,
    parameter int BITDEPTH = 10,
    parameter int OUT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_first,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             err_sync
);

    localparam int LOG_N = $clog2(NTAPS);
    localparam int ACC_W = IN_W + LOG_N;
    // One extra bit so the rounding constant cannot overflow a full-scale sum.
    localparam int S_W   = ACC_W + 1;
    localparam logic [S_W-1:0]        RND     = S_W'(1) << (SHIFT - 1);
    localparam logic signed [S_W-1:0] PIX_MAX = S_W'((64'd1 << BITDEPTH) - 64'd1);

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } state_t;

    state_t                    state, state_nxt;
    logic [LOG_N-1:0]          cnt, cnt_nxt;
    logic signed [ACC_W-1:0]   acc, acc_nxt;
    logic                      err_nxt;
    logic                      load;
    logic                      accept;
    logic signed [ACC_W-1:0]   prod_ext;
    logic signed [S_W-1:0]     s;
    logic signed [S_W-1:0]     r;
    logic [BITDEPTH-1:0]       pix;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign prod_ext = {{LOG_N{in_data[IN_W-1]}}, in_data};

    // Round, normalise and clip the completed sum (acc + final product).
    always_comb begin
        s   = {acc[ACC_W-1], acc} + {{(LOG_N + 1){in_data[IN_W-1]}}, in_data} + RND;
        r   = s >>> SHIFT;
        pix = r[BITDEPTH-1:0];
        if (r[S_W-1]) begin
            pix = '0;
        end else if (r > PIX_MAX) begin
            pix = '1;
        end
    end

    // Next-state: restart on in_first, drop orphan beats, accumulate, complete.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        acc_nxt   = acc;
        err_nxt   = 1'b0;
        load      = 1'b0;
        if (accept) begin
            if (in_first) begin
                acc_nxt   = prod_ext;
                cnt_nxt   = LOG_N'(1);
                state_nxt = ACC;
                err_nxt   = (state == ACC);
            end else if (state == IDLE) begin
                err_nxt = 1'b1;
            end else if (cnt == LOG_N'(NTAPS - 1)) begin
                load      = 1'b1;
                acc_nxt   = '0;
                cnt_nxt   = '0;
                state_nxt = IDLE;
            end else begin
                acc_nxt = acc + prod_ext;
                cnt_nxt = cnt + LOG_N'(1);
            end
        end
    end

    // Accumulator state register and registered framing-error pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            acc      <= '0;
            err_sync <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            acc      <= acc_nxt;
            err_sync <= err_nxt;
        end
    end

    // Single-entry output buffer; a new load wins over a same-cycle consume.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= OUT_W'(pix);
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: doc/interp_tap_accumulator.md
# interp_tap_accumulator

Back-end accumulator for the fractional-sample interpolation datapath. It consumes the per-tap products produced by the tap MCM blocks, already selected for the active fractional position, as a serial stream of one product per cycle. It sums NTAPS products per output sample, then rounds, shifts and clips the sum to the pixel bit depth. It presents each result on a valid/ready output with single-entry buffering.

## Interface
- NTAPS, 8: products summed per output sample; power of two, 2..16
- IN_W, 32: signed product width; matches the 32-bit MCM outputs
- SHIFT, 6: normalisation right-shift; 1..IN_W-1
- BITDEPTH, 10: output pixel bit depth; clip range is [0, 2^BITDEPTH-1]
- OUT_W, 16: output width; must be >= BITDEPTH
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  product beat valid
- in_ready  output  1  product beat accepted when in_valid && in_ready
- in_data  input  IN_W  signed tap product
- in_first  input  1  marks the tap-0 product of a sample
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- out_data  output  OUT_W  clipped pixel, zero-extended
- err_sync  output  1  one-cycle pulse on framing error

## Operation
- Internal state:
  - tap counter cnt, range 0..NTAPS-1.
  - Signed accumulator acc, IN_W+log2(NTAPS) bits wide. Products are sign-extended before addition. No overflow is possible at this width.
- FSM states:
  - IDLE (cnt=0, acc empty).
  - ACC (0<cnt<NTAPS).
  - IDLE also covers the case where a result is held in the output register. Output occupancy is tracked by out_valid alone.
- Accepted beat with in_first=1:
  - acc <= in_data, cnt <= 1.
  - If cnt was nonzero, the partial sum is discarded and err_sync pulses.
- Accepted beat with in_first=0 and cnt=0:
  - The beat is dropped. acc and cnt are unchanged. err_sync pulses.
- Accepted beat with in_first=0 and cnt>0:
  - acc <= acc + in_data, cnt <= cnt+1.
- Beat that completes a sample (cnt reaches NTAPS, or NTAPS=... final tap):
  - s = acc + in_data + 2^(SHIFT-1).
  - r = s >>> SHIFT (arithmetic shift).
  - If r<0, out_data <= 0. If r>2^BITDEPTH-1, out_data <= 2^BITDEPTH-1. Otherwise out_data <= r.
  - out_valid <= 1, cnt <= 0.
  - A final beat that also carries in_first=1 is treated as a restart (first rule), not a completion. With NTAPS>=2 this is unambiguous.
- in_ready = !out_valid || out_ready. It is combinational and applies to every beat, not only the final one.
- Output handshake:
  - out_valid && out_ready clears out_valid, unless a new result loads in the same cycle. In that case out_valid stays 1 and out_data takes the new value.
  - out_data is stable while out_valid && !out_ready.

## Timing
- Reset (async assert, sync deassert expected):
  - out_valid=0, out_data=0, err_sync=0, cnt=0, acc=0.
  - in_ready=1 immediately.
- Latency: out_valid rises on the clock edge that accepts the final tap. It is visible the cycle after the final beat's handshake.
- Throughput: one sample per NTAPS cycles with no bubbles when out_ready=1.
- Back-pressure:
  - While out_valid && !out_ready, in_ready=0 and no beat is accepted.
  - In the cycle out_ready rises, in_ready=1, so both handshakes complete in that cycle.
- err_sync is registered. It is high for exactly the cycle after the offending beat. Back-to-back errors give back-to-back pulses.
- Reset mid-sample:
  - The partial sum is lost and any pending result is lost.
  - No output is produced for that sample.
  - The next accepted beat must carry in_first.

## Test plan
- Nominal: NTAPS=8, eight beats of in_data=64, first beat in_first=1, out_ready=1 -> one cycle after the 8th beat, out_valid=1 and out_data=8 (512+32=544, >>6).
- Negative clip: products {-100,0,0,0,0,0,0,0} -> (-100+32)>>>6 = -2 -> out_data=0. Products {-32,0,...} -> 0>>>6 = 0 -> out_data=0, no clip.
- High clip and width: eight beats of 20000 -> (160000+32)>>6 = 2500 -> out_data=1023. Eight beats of 2^31-1 -> no wrap, out_data=1023.
- Back-pressure: out_ready=0 after the first result; second sample streams 8 beats of 128 -> in_ready=0 from the cycle after the first result. The first result (8) is held. Raise out_ready -> 8 is consumed, beats resume, and the second result is 16 (1024+32=1056, >>6).
- Resync: in_first asserted on the 4th beat of a sample, followed by 8 clean beats of 64 -> err_sync pulses once, exactly one result 8. Separately, a beat with in_first=0 at cnt=0 -> dropped, err_sync pulses, no result.
- Reset mid-operation: assert rst_n=0 after 5 beats -> out_valid=0, out_data=0, in_ready=1 asynchronously. After release, 8 beats of 64 -> out_data=8.
